// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: sequences PLL RESETB, filters LOCK and releases one clean active-low system reset.
// Optional PLL_SUPERVISOR_PER_CHANNEL_RESTART_EN: timeouts restart only unlocked channels, adds failed_mask.
module pll_lock_supervisor #(
   parameter int NUM_PLL             = 1,
   parameter int PLL_RST_CYCLES      = 16,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int LOCK_TIMEOUT_CYCLES = 65536,
   parameter int MAX_RETRIES         = 7,
   parameter int CNT_W               = 17
) (
   input  logic               clock_in,
   input  logic               reset_n,
   input  logic [NUM_PLL-1:0] lock,
   output logic [NUM_PLL-1:0] pll_resetb,
   output logic               sys_reset_n,
   output logic               all_locked,
   output logic [2:0]         state,
   output logic               fail,
   output logic [7:0]         loss_count
`ifdef PLL_SUPERVISOR_PER_CHANNEL_RESTART_EN
   ,
   output logic [NUM_PLL-1:0] failed_mask
`endif
);
   localparam int RW = $clog2(MAX_RETRIES + 2);
   typedef enum logic [2:0] {PLL_RST = 3'd0, WAIT_LOCK = 3'd1, STABLE = 3'd2, RUN = 3'd3, FAIL = 3'd4} st_t;
   st_t st;
   logic [CNT_W-1:0] cnt;
   logic [RW-1:0] retries;
   logic [1:0] rst_q;
   logic [NUM_PLL-1:0] s1, s2, restart_mask;
   logic rst_done, lock_to, stable_done, max_hit;
   assign state       = st;
   assign rst_done    = cnt == CNT_W'(PLL_RST_CYCLES - 1);
   assign lock_to     = cnt == CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   assign stable_done = cnt == CNT_W'(LOCK_STABLE_CYCLES - 1);
   assign max_hit     = retries == RW'(MAX_RETRIES);
`ifdef PLL_SUPERVISOR_PER_CHANNEL_RESTART_EN
   assign restart_mask = s2;
`else
   assign restart_mask = '0;
`endif
   // reset release and lock inputs both pass through two flops before use
   always_ff @(posedge clock_in or negedge reset_n)
      if (!reset_n) begin
         rst_q      <= '0;
         s1         <= '0;
         s2         <= '0;
         all_locked <= 1'b0;
      end else begin
         rst_q      <= {rst_q[0], 1'b1};
         s1         <= lock;
         s2         <= s1;
         all_locked <= &s2;
      end
   always_ff @(posedge clock_in or negedge reset_n)
      if (!reset_n) begin
         st          <= PLL_RST;
         cnt         <= '0;
         retries     <= '0;
         pll_resetb  <= '0;
         sys_reset_n <= 1'b0;
         fail        <= 1'b0;
         loss_count  <= '0;
      end else if (rst_q[1]) begin
         case (st)
            PLL_RST: begin
               cnt <= rst_done ? '0 : cnt + CNT_W'(1);
               if (rst_done) begin
                  st         <= WAIT_LOCK;
                  pll_resetb <= '1;
               end
            end
            WAIT_LOCK:
               if (all_locked) begin
                  cnt <= '0;
                  st  <= STABLE;
               end else if (!lock_to) cnt <= cnt + CNT_W'(1);
               else if (max_hit) begin
                  st         <= FAIL;
                  fail       <= 1'b1;
                  pll_resetb <= '0;
               end else begin
                  cnt        <= '0;
                  retries    <= retries + RW'(1);
                  st         <= PLL_RST;
                  pll_resetb <= restart_mask;
               end
            STABLE:
               if (!all_locked) begin
                  cnt <= '0;
                  st  <= WAIT_LOCK;
               end else if (!stable_done) cnt <= cnt + CNT_W'(1);
               else begin
                  cnt         <= '0;
                  st          <= RUN;
                  sys_reset_n <= 1'b1;
                  retries     <= '0;
               end
            RUN:
               if (!all_locked) begin
                  cnt         <= '0;
                  st          <= WAIT_LOCK;
                  sys_reset_n <= 1'b0;
                  loss_count  <= loss_count + {7'd0, ~&loss_count};
               end
            FAIL: fail <= 1'b1;
            default: begin
               st          <= PLL_RST;
               cnt         <= '0;
               pll_resetb  <= '0;
               sys_reset_n <= 1'b0;
            end
         endcase
      end
`ifdef PLL_SUPERVISOR_PER_CHANNEL_RESTART_EN
   always_ff @(posedge clock_in or negedge reset_n)
      if (!reset_n) failed_mask <= '0;
      else if (rst_q[1] && st == STABLE && all_locked && stable_done) failed_mask <= '0;
      else if (rst_q[1] && st == WAIT_LOCK && !all_locked && lock_to && !max_hit)
         failed_mask <= failed_mask | ~s2;
`endif
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor: randomized bench comparing the supervisor cycle by cycle against a behavioural model.
// Builds with or without PLL_SUPERVISOR_PER_CHANNEL_RESTART_EN.
module tb_pll_lock_supervisor;
   localparam int PRC = 16, SC = 32, TO = 100, MR = 2;
   logic clock_in = 1'b0;
   logic reset_n;
   logic [1:0] lock;
   logic [1:0] pll_resetb;
   logic sys_reset_n, all_locked, fail;
   logic [2:0] state;
   logic [7:0] loss_count;
`ifdef PLL_SUPERVISOR_PER_CHANNEL_RESTART_EN
   logic [1:0] failed_mask;
   logic [1:0] m_fmask;
`endif
   pll_lock_supervisor #(
      .NUM_PLL(2), .PLL_RST_CYCLES(PRC), .LOCK_STABLE_CYCLES(SC),
      .LOCK_TIMEOUT_CYCLES(TO), .MAX_RETRIES(MR), .CNT_W(17)
   ) dut (
      .clock_in(clock_in), .reset_n(reset_n), .lock(lock), .pll_resetb(pll_resetb),
      .sys_reset_n(sys_reset_n), .all_locked(all_locked), .state(state), .fail(fail),
      .loss_count(loss_count)
`ifdef PLL_SUPERVISOR_PER_CHANNEL_RESTART_EN
      , .failed_mask(failed_mask)
`endif
   );
   always #5 clock_in = ~clock_in;
   int n_chk = 0, n_fail = 0;
   int m_state, m_cnt, m_retries, m_loss, m_since;
   logic [1:0] m_resetb;
   logic m_sys, m_fail;
   logic [1:0] hist[$];
   int tmr[2], dly[2], glitch[2];
   bit rnd_dly = 0;
   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask
   task automatic model_reset();
      m_state = 0; m_cnt = 0; m_retries = 0; m_loss = 0; m_since = 0;
      m_resetb = 2'b00; m_sys = 0; m_fail = 0;
      hist = '{2'b00, 2'b00, 2'b00};
`ifdef PLL_SUPERVISOR_PER_CHANNEL_RESTART_EN
      m_fmask = 2'b00;
`endif
   endtask
   // rules of the supervisor, applied once per clock given the filtered lock view
   task automatic fsm(input logic al, input logic [1:0] s2);
      case (m_state)
         0: if (m_cnt == PRC - 1) begin m_cnt = 0; m_state = 1; m_resetb = 2'b11; end
            else m_cnt++;
         1: if (al) begin m_cnt = 0; m_state = 2; end
            else if (m_cnt < TO - 1) m_cnt++;
            else if (m_retries == MR) begin m_state = 4; m_fail = 1; m_resetb = 2'b00; end
            else begin
               m_retries++; m_cnt = 0; m_state = 0;
`ifdef PLL_SUPERVISOR_PER_CHANNEL_RESTART_EN
               m_resetb = s2; m_fmask = m_fmask | ~s2;
`else
               m_resetb = 2'b00;
`endif
            end
         2: if (!al) begin m_cnt = 0; m_state = 1; end
            else if (m_cnt < SC - 1) m_cnt++;
            else begin
               m_cnt = 0; m_state = 3; m_sys = 1; m_retries = 0;
`ifdef PLL_SUPERVISOR_PER_CHANNEL_RESTART_EN
               m_fmask = 2'b00;
`endif
            end
         3: if (!al) begin m_cnt = 0; m_state = 1; m_sys = 0; if (m_loss < 255) m_loss++; end
         default: ;
      endcase
   endtask
   task automatic model_step(input logic [1:0] l);
      logic al;
      logic [1:0] s2;
      al = &hist[0];
      s2 = hist[1];
      if (m_since >= 2) fsm(al, s2);
      if (m_since < 2) m_since++;
      hist.push_back(l);
      void'(hist.pop_front());
   endtask
   task automatic check_all();
      chk("state", state, m_state);
      chk("pll_resetb", pll_resetb, m_resetb);
      chk("sys_reset_n", sys_reset_n, m_sys);
      chk("all_locked", all_locked, &hist[0]);
      chk("fail", fail, m_fail);
      chk("loss_count", loss_count, m_loss);
`ifdef PLL_SUPERVISOR_PER_CHANNEL_RESTART_EN
      chk("failed_mask", failed_mask, m_fmask);
`endif
   endtask
   // behavioural PLLs: lock dly cycles after RESETB releases, optionally glitched low
   task automatic cyc();
      @(negedge clock_in);
      for (int i = 0; i < 2; i++) begin
         if (!m_resetb[i]) begin
            tmr[i] = 0;
            if (rnd_dly) dly[i] = $urandom_range(1, 130);
         end else tmr[i]++;
         lock[i] = m_resetb[i] && tmr[i] >= dly[i] && glitch[i] == 0;
         if (glitch[i] > 0) glitch[i]--;
      end
      @(posedge clock_in);
      if (reset_n) model_step(lock);
      #1 check_all();
   endtask
   task automatic async_reset(input int hold);
      @(negedge clock_in);
      #2 reset_n = 1'b0;
      #1 model_reset();
      chk("arst_state", state, 0);
      chk("arst_resetb", pll_resetb, 0);
      chk("arst_sys", sys_reset_n, 0);
      chk("arst_fail", fail, 0);
      chk("arst_loss", loss_count, 0);
      repeat (hold) cyc();
      reset_n = 1'b1;
   endtask
   task automatic run_until_run(input string tag, input int budget);
      for (int k = 0; k < budget && m_state != 3; k++) cyc();
      repeat (2) cyc();
      chk(tag, state, 3);
   endtask
   initial begin
      int rises;
      bit glitched;
      logic prev;
      reset_n = 1'b0; lock = 2'b00;
      dly = '{10, 10}; glitch = '{0, 0}; tmr = '{0, 0};
      model_reset();
      repeat (3) cyc();
      reset_n = 1'b1;
      glitched = 0;
      for (int k = 0; k < 600 && m_state != 3; k++) begin
         cyc();
         if (!glitched && m_state == 2 && m_cnt == 20) begin glitch[0] = 2; glitched = 1; end
      end
      chk("first_run", state, 3);
      chk("glitch_loss", loss_count, 0);
      repeat (20) cyc();
      glitch[1] = 5;
      repeat (4) cyc();
      chk("drop_sys", sys_reset_n, 0);
      chk("drop_resetb", pll_resetb, 3);
      run_until_run("rerun", 300);
      chk("drop_loss", loss_count, 1);
      rnd_dly = 1;
      for (int k = 0; k < 3000; k++) begin
         cyc();
         if ($urandom_range(0, 99) == 0) glitch[$urandom_range(0, 1)] = $urandom_range(1, 6);
         if ($urandom_range(0, 299) == 0) async_reset($urandom_range(1, 3));
      end
      rnd_dly = 0;
      glitch = '{0, 0};
      dly = '{1000000, 1000000};
      async_reset(2);
      rises = 0;
      for (int k = 0; k < 420; k++) begin
         prev = pll_resetb[0];
         cyc();
         if (!prev && pll_resetb[0]) rises++;
      end
      chk("dead_pulses", rises, 3);
      chk("dead_state", state, 4);
      chk("dead_fail", fail, 1);
      chk("dead_resetb", pll_resetb, 0);
      dly = '{10, 10};
      repeat (50) cyc();
      chk("fail_sticky", state, 4);
      async_reset(2);
      for (int k = 0; k < 300 && !(m_state == 2 && m_cnt == 10); k++) cyc();
      chk("mid_stable", state, 2);
      async_reset(3);
      run_until_run("after_reset", 300);
`ifdef PLL_SUPERVISOR_PER_CHANNEL_RESTART_EN
      dly = '{10, 1000000};
      async_reset(2);
      for (int k = 0; k < 400 && !(m_state == 0 && m_retries == 1); k++) cyc();
      cyc();
      chk("pc_resetb", pll_resetb, 2'b01);
      chk("pc_mask", failed_mask, 2'b10);
      dly = '{10, 10};
      run_until_run("pc_run", 400);
      chk("pc_mask_clr", failed_mask, 0);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
